wb_port_scheduler: RTL and testbench



---
 rtl/wb_port_scheduler_pkg.sv | 16 +
 rtl/wb_port_scheduler_if.sv | 18 +
 rtl/wb_bundle_fifo.sv | 40 ++++
 rtl/wb_port_scheduler.sv | 49 ++++
 tb/tb_wb_port_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/wb_port_scheduler_pkg.sv
// wb_pkg: shared constants, bundle type and head-state encoding for the write-back scheduler
package wb_pkg;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP = 4'h4;
  localparam int NREG = 15;
  localparam int WIDTH = 64;
  typedef struct packed {
    logic [3:0] dstE;
    logic [WIDTH-1:0] valE;
    logic [3:0] dstM;
    logic [WIDTH-1:0] valM;
    logic e_pend;
    logic m_pend;
  } bundle_t;
  typedef enum logic [1:0] {HEAD_EMPTY, HEAD_E, HEAD_M} head_t;
endpackage

// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: write-back bundle input, register-file write port and status outputs
interface wb_port_scheduler_if #(parameter int W = 64, parameter int NREG = 15);
  logic wb_valid;
  logic wb_ready;
  logic [3:0] wb_dstE;
  logic [W-1:0] wb_valE;
  logic [3:0] wb_dstM;
  logic [W-1:0] wb_valM;
  logic rf_we;
  logic [3:0] rf_waddr;
  logic [W-1:0] rf_wdata;
  logic [NREG-1:0] pending;
  logic idle;
  modport master(output wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
                 input wb_ready, rf_we, rf_waddr, rf_wdata, pending, idle);
  modport slave(input wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
                output wb_ready, rf_we, rf_waddr, rf_wdata, pending, idle);
endinterface

// File: rtl/wb_bundle_fifo.sv
// wb_bundle_fifo: DEPTH-entry bundle FIFO with head E-flag clear and per-entry visibility
module wb_bundle_fifo import wb_pkg::*; #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic clr_e,
  input bundle_t din,
  output bundle_t head,
  output logic full,
  output logic empty,
  output bundle_t mem [DEPTH],
  output logic [DEPTH-1:0] valid
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  // pointers wrap naturally at DEPTH; occupancy tracked separately to tell full from empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset: entries outside the valid window are masked
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
    if (clr_e) mem[rptr].e_pend <= 1'b0;
  end
  // an entry is live when its distance from the read pointer is below occupancy
  always_comb
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, AW'(AW'(i) - rptr)} < count;
  assign head = mem[rptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: serialises dual-write bundles onto one register-file write port
module wb_port_scheduler import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  parameter int NREG = 15
) (
  input logic clk,
  input logic rst,
  wb_port_scheduler_if.slave bus
);
  bundle_t din, head;
  bundle_t mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic full, empty, push, pop, clr_e;
  logic [NREG-1:0] pend;
  head_t state;
  // normalise the incoming bundle; when both targets match, the M write wins
  always_comb begin
    din.dstE = bus.wb_dstE;
    din.valE = bus.wb_valE;
    din.dstM = bus.wb_dstM;
    din.valM = bus.wb_valM;
    din.e_pend = bus.wb_dstE != RNONE && bus.wb_dstE != bus.wb_dstM;
    din.m_pend = bus.wb_dstM != RNONE;
  end
  assign push = bus.wb_valid && !full && (din.e_pend || din.m_pend);
  // head phase comes straight from the head entry flags: E is drained before M
  assign state = empty ? HEAD_EMPTY : head.e_pend ? HEAD_E : HEAD_M;
  assign pop = state == HEAD_M || (state == HEAD_E && !head.m_pend);
  assign clr_e = state == HEAD_E && head.m_pend;
  wb_bundle_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_e(clr_e), .din(din),
    .head(head), .full(full), .empty(empty), .mem(mem), .valid(valid)
  );
  // OR together every still-outstanding destination across live entries
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && mem[i].e_pend) pend[mem[i].dstE] = 1'b1;
      if (valid[i] && mem[i].m_pend) pend[mem[i].dstM] = 1'b1;
    end
  end
  assign bus.wb_ready = !full;
  assign bus.rf_we = state != HEAD_EMPTY;
  assign bus.rf_waddr = state == HEAD_E ? head.dstE : state == HEAD_M ? head.dstM : RNONE;
  assign bus.rf_wdata = state == HEAD_E ? head.valE : state == HEAD_M ? head.valM : {W{1'b0}};
  assign bus.pending = pend;
  assign bus.idle = empty;
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed and random stimulus against a write-queue reference model
module tb_wb_port_scheduler;
  localparam int DEPTH = 4, W = 64, NREG = 15;
  logic clk = 0, rst = 1;
  wb_port_scheduler_if #(.W(W), .NREG(NREG)) bus();
  wb_port_scheduler #(.DEPTH(DEPTH), .W(W), .NREG(NREG)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [3:0] a; logic [W-1:0] d; bit last;} wr_t;
  wr_t wq[$];
  int nb = 0;
  logic [3:0] log_a[$];
  logic [W-1:0] log_d[$];
  int pass_cnt = 0, tot_cnt = 0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // reference: a queue of individual register writes, one retired per cycle
  always @(negedge clk) begin : mon
    logic [NREG-1:0] ep;
    logic [3:0] ea;
    logic [W-1:0] ed;
    bit e, m, rdy;
    if (rst) begin
      wq.delete();
      nb = 0;
    end
    ep = '0;
    foreach (wq[i]) ep[wq[i].a] = 1'b1;
    if (wq.size() != 0) begin
      ea = wq[0].a;
      ed = wq[0].d;
    end else begin
      ea = 4'hF;
      ed = '0;
    end
    chk("rf_we", W'(bus.rf_we), W'(wq.size() != 0));
    chk("rf_waddr", W'(bus.rf_waddr), W'(ea));
    chk("rf_wdata", bus.rf_wdata, ed);
    chk("pending", W'(bus.pending), W'(ep));
    chk("idle", W'(bus.idle), W'(wq.size() == 0));
    chk("wb_ready", W'(bus.wb_ready), W'(nb < DEPTH));
    if (!rst) begin
      rdy = nb < DEPTH;
      if (bus.rf_we) begin
        log_a.push_back(bus.rf_waddr);
        log_d.push_back(bus.rf_wdata);
      end
      if (wq.size() != 0) begin
        if (wq[0].last) nb--;
        void'(wq.pop_front());
      end
      if (bus.wb_valid && rdy) begin
        e = bus.wb_dstE != 4'hF && bus.wb_dstE != bus.wb_dstM;
        m = bus.wb_dstM != 4'hF;
        if (e) wq.push_back('{bus.wb_dstE, bus.wb_valE, !m});
        if (m) wq.push_back('{bus.wb_dstM, bus.wb_valM, 1'b1});
        if (e || m) nb++;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] de, input logic [W-1:0] ve, input logic [3:0] dm, input logic [W-1:0] vm);
    bit r;
    int n = 0;
    bus.wb_valid = 1;
    bus.wb_dstE = de;
    bus.wb_valE = ve;
    bus.wb_dstM = dm;
    bus.wb_valM = vm;
    do begin
      @(negedge clk);
      r = bus.wb_ready;
      step();
      n++;
    end while (!r && n < 50);
    chk("accept", W'(r), W'(1));
    bus.wb_valid = 0;
  endtask
  function automatic int count_data(input logic [W-1:0] d);
    int c = 0;
    foreach (log_d[i]) if (log_d[i] == d) c++;
    return c;
  endfunction
  initial begin
    int base;
    bus.wb_valid = 0;
    bus.wb_dstE = 4'hF;
    bus.wb_valE = '0;
    bus.wb_dstM = 4'hF;
    bus.wb_valM = '0;
    step();
    chk("rst_we", W'(bus.rf_we), 0);
    chk("rst_waddr", W'(bus.rf_waddr), 'hF);
    chk("rst_idle", W'(bus.idle), 1);
    chk("rst_ready", W'(bus.wb_ready), 1);
    rst = 0;
    step();
    send(4'd3, 'h11, 4'hF, 0);
    chk("t1_we", W'(bus.rf_we), 1);
    chk("t1_waddr", W'(bus.rf_waddr), 3);
    chk("t1_wdata", bus.rf_wdata, 'h11);
    chk("t1_pend", W'(bus.pending), 'h8);
    step();
    chk("t1_pend_done", W'(bus.pending), 0);
    chk("t1_idle", W'(bus.idle), 1);
    send(4'd4, 'h100, 4'd0, 'hAB);
    chk("t2_waddr_e", W'(bus.rf_waddr), 4);
    chk("t2_wdata_e", bus.rf_wdata, 'h100);
    chk("t2_pend_e", W'(bus.pending), 'h11);
    step();
    chk("t2_waddr_m", W'(bus.rf_waddr), 0);
    chk("t2_wdata_m", bus.rf_wdata, 'hAB);
    chk("t2_pend_m", W'(bus.pending), 'h1);
    step();
    chk("t2_pend_done", W'(bus.pending), 0);
    send(4'd4, 'h108, 4'd4, 'h55);
    chk("t3_waddr", W'(bus.rf_waddr), 4);
    chk("t3_wdata", bus.rf_wdata, 'h55);
    chk("t3_pend", W'(bus.pending), 'h10);
    step();
    chk("t3_we_done", W'(bus.rf_we), 0);
    base = log_a.size();
    for (int i = 0; i < 6; i++) send(4'(i), W'(i + 'h200), 4'(i + 7), W'(i + 'h300));
    chk("t4_full", W'(bus.wb_ready), 0);
    send(4'd6, 'h206, 4'd13, 'h306);
    repeat (12) step();
    chk("t4_nwrites", W'(log_a.size() - base), 14);
    for (int i = 0; i < 7; i++) begin
      chk("t4_order_e", W'(log_a[base + 2 * i]), W'(i));
      chk("t4_order_m", W'(log_a[base + 2 * i + 1]), W'(i + 7));
    end
    base = log_a.size();
    send(4'd3, 'h31, 4'hF, 0);
    send(4'hF, 'h99, 4'hF, 'h98);
    send(4'd5, 'h51, 4'hF, 0);
    repeat (3) step();
    chk("t5_nwrites", W'(log_a.size() - base), 2);
    chk("t5_first", W'(log_a[base]), 3);
    chk("t5_second", W'(log_a[base + 1]), 5);
    send(4'd1, 'hA, 4'd2, 'hB);
    step();
    chk("t6_waddr_m", W'(bus.rf_waddr), 2);
    rst = 1;
    #1;
    chk("t6_we_async", W'(bus.rf_we), 0);
    chk("t6_pend_async", W'(bus.pending), 0);
    chk("t6_idle_async", W'(bus.idle), 1);
    step();
    rst = 0;
    base = log_a.size();
    send(4'd6, 'h66, 4'hF, 0);
    repeat (2) step();
    chk("t6_nwrites", W'(log_a.size() - base), 1);
    chk("t6_after", W'(log_a[base]), 6);
    chk("popq_no_e", W'(count_data('h108)), 0);
    chk("rst_no_m", W'(count_data('hB)), 0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] de, dm;
      de = $urandom_range(0, 4) == 0 ? 4'hF : 4'($urandom_range(0, 14));
      dm = $urandom_range(0, 3) == 0 ? 4'hF : $urandom_range(0, 5) == 0 ? de : 4'($urandom_range(0, 14));
      bus.wb_valid = $urandom_range(0, 3) != 0;
      bus.wb_dstE = de;
      bus.wb_valE = {$urandom, $urandom};
      bus.wb_dstM = dm;
      bus.wb_valM = {$urandom, $urandom};
      step();
    end
    bus.wb_valid = 0;
    repeat (2 * DEPTH + 2) step();
    chk("drain_idle", W'(bus.idle), 1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
